// File: rtl/hqm_rcfwl_gclk_mc_sync_pkg.sv
// Shared types and defaults for the MC sync aligner.
// Optional debug counter: HQM_RCFWL_GCLK_MC_SYNC_DBG_EN.
package hqm_rcfwl_gclk_mc_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_RATIO_W  = 4;
  localparam int DEF_PERIOD_W = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int SYNC_DEPTH   = 2;
  localparam int MATCH_W      = 4;

endpackage

// File: rtl/hqm_rcfwl_gclk_mc_sync_edge.sv
// Synchronizer for the forwarded PLL sync plus rising-edge detect.
// Optional debug counter: HQM_RCFWL_GCLK_MC_SYNC_DBG_EN (not used here).
module hqm_rcfwl_gclk_mc_sync_edge
  import hqm_rcfwl_gclk_mc_sync_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      last_q <= sync_q[SYNC_DEPTH-1];
      evt    <= sync_q[SYNC_DEPTH-1] & ~last_q;
    end
  end

endmodule

// File: rtl/hqm_rcfwl_gclk_mc_sync_align.sv
// MC sync aligner: qualifies sync period, locks, emits aligned clken.
// Optional debug counter: HQM_RCFWL_GCLK_MC_SYNC_DBG_EN.
module hqm_rcfwl_gclk_mc_sync_align
  import hqm_rcfwl_gclk_mc_sync_pkg::*;
#(
  parameter int RATIO_W  = DEF_RATIO_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mc_pll_sync_in,
  input  logic                cfg_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [RATIO_W-1:0]  cfg_ratio,
  input  logic                sync_err_clr,
  output logic                mc_clken,
  output logic                mc_sync_pulse,
  output logic                locked,
`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
  output logic [7:0]          dbg_lock_loss_cnt,
`endif
  output logic                sync_err
);

  logic                sync_evt;
  state_t              state;
  logic [PERIOD_W-1:0] per_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MATCH_W-1:0]  match_nxt;
  logic                seeded;
  logic [RATIO_W-1:0]  div_cnt;
  logic [RATIO_W-1:0]  ratio_m1;
  logic                per_match;
  logic                per_miss;
  logic                lose;

  hqm_rcfwl_gclk_mc_sync_edge u_edge (
    .clk (clk),
    .rst (rst),
    .din (mc_pll_sync_in),
    .evt (sync_evt)
  );

  assign ratio_m1  = (cfg_ratio == '0) ? '0 : cfg_ratio - 1'b1;
  assign per_match = (per_cnt == cfg_period);
  assign per_miss  = ({1'b0, per_cnt} ==
                      ({1'b0, cfg_period} + (PERIOD_W+1)'(1)));
  assign lose      = (state == LOCKED) &&
                     (sync_evt ? !per_match : per_miss);
  assign match_nxt = !seeded  ? '0 :
                     per_match ? match_cnt + 1'b1 :
                                 MATCH_W'(1);
  assign mc_clken  = locked && (div_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '1;
    end else if (sync_evt) begin
      per_cnt <= PERIOD_W'(1);
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      match_cnt     <= '0;
      seeded        <= 1'b0;
      locked        <= 1'b0;
      div_cnt       <= '0;
      mc_sync_pulse <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      mc_sync_pulse <= sync_evt & cfg_en & (state != IDLE);
      if (cfg_en && lose) begin
        sync_err <= 1'b1;
      end else if (sync_err_clr) begin
        sync_err <= 1'b0;
      end
      if (!cfg_en) begin
        state     <= IDLE;
        match_cnt <= '0;
        seeded    <= 1'b0;
        locked    <= 1'b0;
        div_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ACQ;
          end
          ACQ: begin
            if (sync_evt) begin
              seeded    <= 1'b1;
              match_cnt <= match_nxt;
              if (match_nxt == MATCH_W'(LOCK_CNT)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                div_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (lose) begin
              state     <= ACQ;
              locked    <= 1'b0;
              match_cnt <= '0;
              div_cnt   <= '0;
            end else if (sync_evt) begin
              div_cnt <= '0;
            end else if (div_cnt == ratio_m1) begin
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_lock_loss_cnt <= '0;
    end else if (cfg_en && lose && dbg_lock_loss_cnt != 8'hff) begin
      dbg_lock_loss_cnt <= dbg_lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hqm_rcfwl_gclk_mc_sync_align.sv
// Bench for the MC sync aligner: directed steps plus random sync trains
// checked each cycle against an event-timeline reference model.
module tb_hqm_rcfwl_gclk_mc_sync_align;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_in = 1'b0;
  logic       cfg_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] cfg_period = 8'd8;
  logic [3:0] cfg_ratio = 4'd4;
  logic       mc_clken;
  logic       mc_sync_pulse;
  logic       locked;
  logic       sync_err;
`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
  logic [7:0] dbg;
`endif

  int npass = 0;
  int ntot  = 0;
  int en_cnt = 0;

  // reference model: timeline of sync events and lock anchor
  bit hq[$];
  int m_t, m_last, m_anchor, m_match, m_loss;
  bit m_evt, m_active, m_locked, m_seeded, m_err, m_pulse, m_clken;

  hqm_rcfwl_gclk_mc_sync_align dut (
    .clk            (clk),
    .rst            (rst),
    .mc_pll_sync_in (sync_in),
    .cfg_en         (cfg_en),
    .cfg_period     (cfg_period),
    .cfg_ratio      (cfg_ratio),
    .sync_err_clr   (err_clr),
    .mc_clken       (mc_clken),
    .mc_sync_pulse  (mc_sync_pulse),
    .locked         (locked),
`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
    .dbg_lock_loss_cnt (dbg),
`endif
    .sync_err       (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    hq.delete();
    repeat (4) hq.push_back(1'b0);
    m_t = 0; m_last = -1000; m_anchor = 0; m_match = 0; m_loss = 0;
    m_evt = 0; m_active = 0; m_locked = 0; m_seeded = 0;
    m_err = 0; m_pulse = 0; m_clken = 0;
  endfunction

  function automatic void m_edge();
    int pc, n;
    bit ev, lose;
    ev = m_evt;
    pc = m_t - m_last;
    if (pc > 255) pc = 255;
    n = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
    m_pulse = ev && cfg_en && m_active;
    lose = 0;
    if (!cfg_en) begin
      m_active = 0; m_locked = 0; m_seeded = 0; m_match = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_locked) begin
      if (ev) begin
        if (!m_seeded) begin
          m_seeded = 1; m_match = 0;
        end else begin
          m_match = (pc == int'(cfg_period)) ? m_match + 1 : 1;
        end
        if (m_match == LOCK) begin
          m_locked = 1; m_anchor = m_t + 1;
        end
      end
    end else if ((ev && pc != int'(cfg_period)) ||
                 (!ev && pc == int'(cfg_period) + 1)) begin
      lose = 1; m_locked = 0; m_match = 0;
      if (m_loss < 255) m_loss++;
    end else if (ev) begin
      m_anchor = m_t + 1;
    end
    m_err = lose ? 1'b1 : (err_clr ? 1'b0 : m_err);
    if (ev) m_last = m_t;
    m_t++;
    hq.push_back(sync_in);
    if (hq.size() > 8) void'(hq.pop_front());
    m_evt = hq[$-2] && !hq[$-3];
    m_clken = m_locked && (((m_t - m_anchor) % n) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) m_reset();
    else m_edge();
    if (mc_clken === 1'b1) en_cnt++;
    chk("locked", locked, m_locked);
    chk("mc_clken", mc_clken, m_clken);
    chk("mc_sync_pulse", mc_sync_pulse, m_pulse);
    chk("sync_err", sync_err, m_err);
`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
    chk("dbg_lock_loss_cnt", dbg, m_loss);
`endif
  endtask

  task automatic pulse_gap(input int gap);
    int w;
    w = $urandom_range(1, 2);
    sync_in = 1'b1;
    repeat (w) step();
    sync_in = 1'b0;
    repeat (gap - w) step();
  endtask

  task automatic reprog(input int per, input int rat);
    cfg_en = 1'b0;
    step();
    cfg_period = 8'(per);
    cfg_ratio = 4'(rat);
    cfg_en = 1'b1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    bit save_err;
    int save_loss;
    m_reset();
    repeat (2) step();
    chk("reset_locked", locked, 0);
    chk("reset_clken", mc_clken, 0);
    chk("reset_pulse", mc_sync_pulse, 0);
    chk("reset_err", sync_err, 0);
    rst = 1'b0;

    // acquire: period 8, ratio 4
    cfg_en = 1'b1;
    repeat (4) pulse_gap(8);
    chk("acq_not_yet", locked, 0);
    pulse_gap(8);
    chk("lock_acquired", locked, 1);
    en_cnt = 0;
    repeat (2) pulse_gap(8);
    chk("clken_every4", en_cnt, 4);
    chk("no_err_locked", sync_err, 0);

    // early sync
    pulse_gap(6);
    pulse_gap(8);
    chk("early_unlock", locked, 0);
    chk("early_err", sync_err, 1);
    repeat (3) pulse_gap(8);
    chk("relock_pending", locked, 0);
    pulse_gap(8);
    chk("relocked", locked, 1);
    clear_err();
    chk("err_cleared", sync_err, 0);

    // missing sync
    sync_in = 1'b0;
    repeat (14) step();
    chk("missing_unlock", locked, 0);
    chk("missing_err", sync_err, 1);
    clear_err();
    chk("err_cleared2", sync_err, 0);

    // ratio edge cases
    reprog(8, 0);
    repeat (6) pulse_gap(8);
    en_cnt = 0;
    repeat (2) pulse_gap(8);
    chk("ratio0_cont", en_cnt, 16);
    reprog(8, 1);
    repeat (6) pulse_gap(8);
    en_cnt = 0;
    repeat (2) pulse_gap(8);
    chk("ratio1_cont", en_cnt, 16);
    reprog(8, 3);
    repeat (6) pulse_gap(8);
    en_cnt = 0;
    repeat (2) pulse_gap(8);
    chk("ratio3_realign", en_cnt, 6);

    // random trains, occasional jitter, random clears
    for (int it = 0; it < 30; it++) begin
      int per;
      per = $urandom_range(4, 20);
      reprog(per, $urandom_range(0, 15));
      for (int p = 0; p < 10; p++) begin
        int gap;
        gap = per;
        if ($urandom_range(0, 9) == 0) gap = per + $urandom_range(0, 4) - 2;
        if (gap < 4) gap = 4;
        err_clr = ($urandom_range(0, 7) == 0);
        pulse_gap(gap);
        err_clr = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        sync_in = 1'b0;
        repeat (per + 4) step();
      end
    end

    // cfg_en drop while locked
    reprog(8, 4);
    repeat (6) pulse_gap(8);
    chk("pre_drop_locked", locked, 1);
    save_err = m_err;
    save_loss = m_loss;
    cfg_en = 1'b0;
    pulse_gap(8);
    chk("drop_unlocked", locked, 0);
    chk("drop_err_kept", sync_err, save_err);
`ifdef HQM_RCFWL_GCLK_MC_SYNC_DBG_EN
    chk("drop_dbg_kept", dbg, save_loss);
`endif

    // async reset mid-lock
    cfg_en = 1'b1;
    repeat (6) pulse_gap(8);
    chk("pre_rst_locked", locked, 1);
    sync_in = 1'b1;
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_clken", mc_clken, 0);
    chk("arst_pulse", mc_sync_pulse, 0);
    chk("arst_err", sync_err, 0);
    m_reset();
    step();
    #2 rst = 1'b0;
    sync_in = 1'b0;
    repeat (3) step();
    repeat (2) pulse_gap(8);
    chk("post_rst_reacq", locked, 0);
    repeat (4) pulse_gap(8);
    chk("post_rst_locked", locked, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
